// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversampling ratio.
// The receiver uses the same encodings so both directions decode identically.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OS_TICKS = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: shifts a latched byte out LSB first as start/data/parity/stop,
// paced by a 16x oversampling tick, and pulses TX_DONE_TICK as it returns to IDLE.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = PAR_NONE
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       S_TICK,
    input  logic       TX_START,
    input  logic [7:0] DIN,
    output logic       TX,
    output logic       BUSY,
    output logic       TX_DONE_TICK
);

    localparam logic [4:0] OS_LAST   = 5'(OS_TICKS - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    state_t     state_reg, state_next;
    logic [4:0] s_reg, s_next;
    logic [2:0] n_reg, n_next;
    logic [7:0] b_reg, b_next;
    logic       p_reg, p_next;
    logic       tx_reg, tx_next;
    logic       done_reg, done_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        p_next     = p_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A tick arriving with the start request is deliberately not counted.
                if (TX_START) begin
                    b_next     = DIN;
                    s_next     = '0;
                    p_next     = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (S_TICK) begin
                    if (s_reg == OS_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (S_TICK) begin
                    if (s_reg == OS_LAST) begin
                        s_next = '0;
                        p_next = p_reg ^ b_reg[0];
                        b_next = {1'b0, b_reg[7:1]};
                        if (n_reg == BIT_LAST) begin
                            state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            PAR: begin
                if (S_TICK) begin
                    if (s_reg == OS_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (S_TICK) begin
                    if (s_reg == STOP_LAST) begin
                        s_next     = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so TX changes on the same edge as the FSM.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            PAR:     tx_next = (PARITY == PAR_ODD) ? ~p_next : p_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    assign TX           = tx_reg;
    assign BUSY         = (state_reg != IDLE);
    assign TX_DONE_TICK = done_reg;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART without FIFO, the transmit-side consumer of the 16× oversampling tick produced by the baud-rate generator. It accepts one parallel byte on a single-cycle start strobe and shifts it out LSB first as an asynchronous frame: start bit, data bits, optional parity, stop bit(s). It signals completion with a one-cycle pulse. There is no buffering: the host must wait for the done pulse or for BUSY to drop before starting the next frame.

## Interface
- DBIT, default 8: number of data bits per frame, 5..8.
- SB_TICK, default 16: stop-bit length in S_TICKs; 16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- S_TICK  in  1  one-CLK pulse at 16× the baud rate, from the baud-rate generator.
- TX_START  in  1  request to transmit DIN; sampled only in IDLE.
- DIN  in  8  byte to send; bits [DBIT-1:0] are used, latched when TX_START is accepted.
- TX  out  1  serial line, registered, idles high.
- BUSY  out  1  high in every state except IDLE.
- TX_DONE_TICK  out  1  one-CLK pulse at the end of the stop period.

## Operation
- **States:** IDLE, START, DATA, PAR, STOP.
- **Counters:**
  - s: 5-bit tick counter, wide enough for SB_TICK up to 32.
  - n: 3-bit bit index.
  - b: 8-bit shift register.
  - p: parity accumulator.
- **IDLE:** TX=1. If TX_START=1, then b←DIN, s←0, p←0, and go to START. Otherwise hold.
- **START:** TX=0.
  - On S_TICK: if s=15, then s←0, n←0, go to DATA; else s←s+1.
- **DATA:** TX=b[0].
  - On S_TICK with s=15: s←0, p←p^b[0], b←b>>1.
  - Then, if n=DBIT-1, go to PAR when PARITY≠0, else to STOP.
  - Otherwise n←n+1 and stay in DATA.
  - On S_TICK with s≠15: s←s+1.
- **PAR:** TX=p for even parity, ~p for odd parity.
  - On S_TICK: if s=15, then s←0 and go to STOP; else s←s+1.
- **STOP:** TX=1.
  - On S_TICK: if s=SB_TICK-1, pulse TX_DONE_TICK and go to IDLE; else s←s+1.
- **TX_START outside IDLE:** ignored, with no effect on the frame in flight or on the next frame.
- **DIN changes after acceptance:** no effect on the frame in flight.
- **Cycles without S_TICK:** state, s and TX hold.
- **Reset, including mid-frame:**
  - State returns to IDLE; s, n, b, p are cleared.
  - TX=1, BUSY=0, TX_DONE_TICK=0.
  - The partial frame is abandoned, and no done pulse is produced for it.

## Timing
- **Acceptance:** TX_START is sampled on rising edge k. TX goes low from edge k+1, and BUSY=1 from edge k+1.
- **Bit lengths:**
  - Every start, data and parity bit lasts exactly 16 S_TICKs.
  - The stop period lasts SB_TICK S_TICKs.
  - The first start-bit tick is the first S_TICK sampled after edge k.
- **TX output:** comes from a register driven by the next-state logic, so it is glitch-free. TX transitions on the same edge that the state or the shift register updates.
- **Done pulse:** TX_DONE_TICK is high for exactly one CLK, in the cycle following the final stop S_TICK edge. It is coincident with the return to IDLE: BUSY=0 in that same cycle.
- **Back-to-back frames:** TX_START asserted during the TX_DONE_TICK cycle is accepted, because the state is already IDLE. This gives back-to-back frames with no extra idle bit.
- **Frame length:** (1 + DBIT + (PARITY≠0) ) × 16 + SB_TICK S_TICKs. With defaults this is 160 ticks, i.e. 10 bit times.
- **S_TICK and TX_START in the same IDLE cycle:** the tick is not counted toward the start bit.

## Structure
- **Shared package uart_pkg:**
  - State encoding constants (IDLE=0, START=1, DATA=2, PAR=3, STOP=4, 3-bit).
  - Parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
  - Oversampling constant OS_TICKS=16.
  - The future uart_rx uses the same package.
- **Implementation:** single module with no sub-modules. Use the two-process style: state/data registers plus next-state logic. The baud-rate generator is instantiated beside it at top level, not inside.

## Test plan
- **Reset values:** assert RESET for 3 cycles with TX_START=1 → TX=1, BUSY=0, TX_DONE_TICK=0 throughout, and no frame starts until RESET is released.
- **Default 8N1 frame:** S_TICK every 4 CLK, DIN=0x55, TX_START pulse → TX sequence is 0,1,0,1,0,1,0,1,0,1, each bit 64 CLK. TX_DONE_TICK is a single-cycle pulse 640 CLK after the first low.
- **Even parity:** PARITY=1, DIN=0x07 → parity bit 1; DIN=0x03 → parity bit 0. With PARITY=2 and DIN=0x07 → parity bit 0.
- **Ignored start and latched data:** TX_START re-pulsed mid-data with DIN=0xFF → the frame in flight is unchanged, only one TX_DONE_TICK occurs, and no second frame follows.
- **Reset mid-frame:** RESET during data bit 3 → TX=1 and BUSY=0 on the next edge, and no done pulse. A subsequent frame with 0xA3 transmits correctly.
- **Back-to-back, 2 stop bits:** TX_START held high with SB_TICK=32 and DIN 0x00 then 0xFF → two frames with a stop period of exactly 32 ticks between them and the next start bit immediately after.
